// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: captures two operands on a start edge and
// compares their biased keys MSB-first, one bit per clock, with early exit.
module seq_magnitude_comparator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             a_neg,
    output logic             b_neg,
    output logic             mode_err,
    output logic [CNT_W-1:0] cmp_count
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] BIAS = (WIDTH + 1)'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    typedef struct packed {
        logic             neg;
        logic [WIDTH-1:0] mag;
        logic [WIDTH:0]   key;
    } opinfo_t;

    // The key maps every format onto one unsigned ordering, so the scan
    // never needs to know which format it is comparing.
    function automatic opinfo_t decode(input logic [WIDTH-1:0] x, input logic [1:0] m);
        opinfo_t          r;
        logic [WIDTH-2:0] low;
        low   = x[WIDTH-2:0];
        r.neg = 1'b0;
        r.mag = x;
        r.key = {1'b0, x};
        case (m)
            2'b01: begin
                r.neg = x[WIDTH-1];
                r.mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
                r.key = {1'b0, ~x[WIDTH-1], low};
            end
            2'b10: begin
                r.neg = x[WIDTH-1] & (low != '0);
                r.mag = {1'b0, low};
                r.key = r.neg ? (BIAS - {2'b00, low}) : (BIAS + {2'b00, low});
            end
            default: ;
        endcase
        return r;
    endfunction

    state_t           state, state_next;
    logic             start_prev;
    logic             start_rise;
    logic [WIDTH-1:0] a_r, b_r;
    logic [1:0]       mode_r;
    logic [WIDTH:0]   key_a, key_b;
    logic [IDX_W-1:0] idx;
    logic             bit_diff;
    logic             scan_end;
    opinfo_t          dec_a, dec_b;

    assign dec_a      = decode(a_r, mode_r);
    assign dec_b      = decode(b_r, mode_r);
    assign start_rise = start & ~start_prev;
    assign bit_diff   = key_a[idx] ^ key_b[idx];
    assign scan_end   = bit_diff | (idx == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_rise) state_next = LOAD;
            LOAD:    state_next = SCAN;
            SCAN:    if (scan_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // start_prev resets high so a start held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev <= 1'b1;
            a_r        <= '0;
            b_r        <= '0;
            mode_r     <= '0;
            key_a      <= '0;
            key_b      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            eq         <= 1'b0;
            gt         <= 1'b0;
            lt         <= 1'b0;
            a_mag      <= '0;
            b_mag      <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            mode_err   <= 1'b0;
            cmp_count  <= '0;
        end else begin
            start_prev <= start;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        a_r    <= a_in;
                        b_r    <= b_in;
                        mode_r <= mode;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    key_a    <= dec_a.key;
                    key_b    <= dec_b.key;
                    a_mag    <= dec_a.mag;
                    b_mag    <= dec_b.mag;
                    a_neg    <= dec_a.neg;
                    b_neg    <= dec_b.neg;
                    mode_err <= (mode_r == 2'b11);
                    idx      <= IDX_W'(WIDTH);
                end
                SCAN: begin
                    if (scan_end) begin
                        eq        <= ~bit_diff;
                        gt        <= bit_diff & key_a[idx];
                        lt        <= bit_diff & key_b[idx];
                        done      <= 1'b1;
                        cmp_count <= cmp_count + CNT_W'(1);
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised and directed bench for seq_magnitude_comparator (WIDTH=4),
// checked against an integer-valued reference model.
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a_in, b_in;
    logic             busy, done, eq, gt, lt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg, mode_err;
    logic [CNT_W-1:0] cmp_count;

    int n_cmp = 0;
    int n_fail = 0;
    int model_count = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .eq(eq), .gt(gt), .lt(lt), .a_mag(a_mag), .b_mag(b_mag),
        .a_neg(a_neg), .b_neg(b_neg), .mode_err(mode_err), .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;

    // Reference: signed value of an operand in the given format.
    function automatic int model_value(input logic [3:0] x, input logic [1:0] m);
        logic [2:0] low;
        low = x[2:0];
        case (m)
            2'b01:   return x[3] ? int'(x) - 16 : int'(x);
            2'b10:   return x[3] ? -int'(low) : int'(low);
            default: return int'(x);
        endcase
    endfunction

    // Reference: cycles from the start edge to the first cycle done is visible.
    function automatic int model_latency(input int va, input int vb, input logic [1:0] m);
        int ka, kb, k;
        ka = (m == 2'b01 || m == 2'b10) ? va + 8 : va;
        kb = (m == 2'b01 || m == 2'b10) ? vb + 8 : vb;
        k  = 5;
        for (int i = 4; i >= 0; i--) begin
            if (ka[i] != kb[i]) begin
                k = 5 - i;
                break;
            end
        end
        return 1 + k;
    endfunction

    // Launches one comparison and waits (bounded) for done; lat=-1 on timeout.
    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                                 output int lat);
        @(negedge clk);
        mode = m; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 2'b00; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, eq, gt, lt, a_mag, b_mag, a_neg, b_neg, mode_err, cmp_count} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b eq/gt/lt=%b%b%b mags=%0d/%0d cnt=%0d, need all 0",
                     busy, done, eq, gt, lt, a_mag, b_mag, cmp_count);
        end
        reset = 1'b0;
        model_count = 0;
    endtask

    typedef struct packed {
        logic [1:0] m;
        logic [3:0] a, b;
        logic [3:0] lat;
        logic [2:0] egl;
        logic [3:0] amag, bmag;
        logic [1:0] negs;
        logic       err;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [6];
        int   lat;
        tbl[0] = '{2'b00, 4'b0111, 4'b0011, 4'd4, 3'b010, 4'd7, 4'd3, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 4'b1000, 4'b0111, 4'd3, 3'b001, 4'd8, 4'd7, 2'b10, 1'b0};
        tbl[2] = '{2'b10, 4'b1000, 4'b0000, 4'd6, 3'b100, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[3] = '{2'b10, 4'b1011, 4'b1101, 4'd4, 3'b010, 4'd3, 4'd5, 2'b11, 1'b0};
        tbl[4] = '{2'b11, 4'b0010, 4'b0010, 4'd6, 3'b100, 4'd2, 4'd2, 2'b00, 1'b1};
        tbl[5] = '{2'b00, 4'b0010, 4'b0001, 4'd5, 3'b010, 4'd2, 4'd1, 2'b00, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].m, tbl[i].a, tbl[i].b, lat);
            model_count++;
            n_cmp++;
            if (lat !== int'(tbl[i].lat)) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_latency: got %0d, need %0d", i, lat, tbl[i].lat);
            end
            if (lat < 0) continue;
            n_cmp++;
            if ({eq, gt, lt} !== tbl[i].egl) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_result: eq/gt/lt got %b%b%b, need %b", i, eq, gt, lt, tbl[i].egl);
            end
            n_cmp++;
            if ({a_mag, b_mag} !== {tbl[i].amag, tbl[i].bmag}) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_mag: got %0d/%0d, need %0d/%0d", i, a_mag, b_mag, tbl[i].amag, tbl[i].bmag);
            end
            n_cmp++;
            if ({a_neg, b_neg} !== tbl[i].negs) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_neg: got %b%b, need %b", i, a_neg, b_neg, tbl[i].negs);
            end
            n_cmp++;
            if (mode_err !== tbl[i].err) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_mode_err: got %b, need %b", i, mode_err, tbl[i].err);
            end
            n_cmp++;
            if (cmp_count !== CNT_W'(model_count) || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_count_busy: got cnt=%0d busy=%b, need cnt=%0d busy=1", i, cmp_count, busy, model_count);
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_after_done: busy/done got %b%b, need 00", i, busy, done);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        @(negedge clk);
        mode = 2'b00; a_in = 4'd5; b_in = 4'd5; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
            start = (i == 1 || i == 3 || i == 5) ? 1'b1 : 1'b0;
        end
        model_count++;
        n_cmp++;
        if (dones !== 1) begin
            n_fail++;
            $display("[TB] FAIL busy_starts_done_count: got %0d pulses, need 1", dones);
        end
        n_cmp++;
        if (cmp_count !== CNT_W'(model_count) || busy !== 1'b0 || eq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_starts_state: got cnt=%0d busy=%b eq=%b, need cnt=%0d busy=0 eq=1",
                     cmp_count, busy, eq, model_count);
        end
    endtask

    task automatic test_start_held_through_reset();
        int seen = 0;
        int lat;
        @(negedge clk);
        start = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy || done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL held_start_no_trigger: got %0d active cycles, need 0", seen);
        end
        start = 1'b0;
        applyStimulus(2'b00, 4'd3, 4'd12, lat);
        model_count++;
        n_cmp++;
        if (lat !== 3 || lt !== 1'b1 || cmp_count !== CNT_W'(model_count)) begin
            n_fail++;
            $display("[TB] FAIL held_start_retrigger: got lat=%0d lt=%b cnt=%0d, need lat=3 lt=1 cnt=%0d",
                     lat, lt, cmp_count, model_count);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dones = 0;
        @(negedge clk);
        mode = 2'b00; a_in = 4'd9; b_in = 4'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_scan_busy: got %b, need 1", busy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, eq, gt, lt, a_mag, b_mag, a_neg, b_neg, mode_err, cmp_count} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_scan_reset: got busy=%b done=%b eq/gt/lt=%b%b%b mags=%0d/%0d cnt=%0d, need all 0",
                     busy, done, eq, gt, lt, a_mag, b_mag, cmp_count);
        end
        reset = 1'b0;
        model_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL mid_scan_aborted: got %0d active cycles, need 0", dones);
        end
    endtask

    task automatic test_random(input int n);
        logic [1:0] m;
        logic [3:0] a, b;
        int va, vb, lat, exp_lat;
        logic [2:0] egl;
        for (int i = 0; i < n; i++) begin
            m = 2'($urandom_range(0, 3));
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            va = model_value(a, m);
            vb = model_value(b, m);
            exp_lat = model_latency(va, vb, m);
            egl = {va == vb, va > vb, va < vb};
            applyStimulus(m, a, b, lat);
            model_count++;
            n_cmp++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("[TB] FAIL rnd%0d_latency: m=%b a=%b b=%b got %0d, need %0d", i, m, a, b, lat, exp_lat);
            end
            if (lat < 0) continue;
            n_cmp++;
            if ({eq, gt, lt} !== egl) begin
                n_fail++;
                $display("[TB] FAIL rnd%0d_result: m=%b a=%b b=%b eq/gt/lt got %b%b%b, need %b", i, m, a, b, eq, gt, lt, egl);
            end
            n_cmp++;
            if ({a_mag, b_mag, a_neg, b_neg} !== {4'(va < 0 ? -va : va), 4'(vb < 0 ? -vb : vb), va < 0, vb < 0}) begin
                n_fail++;
                $display("[TB] FAIL rnd%0d_signmag: m=%b a=%b b=%b got mag=%0d/%0d neg=%b%b, need values %0d/%0d",
                         i, m, a, b, a_mag, b_mag, a_neg, b_neg, va, vb);
            end
            n_cmp++;
            if (mode_err !== (m == 2'b11) || cmp_count !== CNT_W'(model_count)) begin
                n_fail++;
                $display("[TB] FAIL rnd%0d_err_count: got err=%b cnt=%0d, need err=%b cnt=%0d",
                         i, mode_err, cmp_count, m == 2'b11, CNT_W'(model_count));
            end
        end
    endtask

    task automatic test_counter_wrap();
        n_cmp++;
        if (model_count !== 256 || cmp_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL counter_wrap: after %0d compares got cnt=%0d, need 0", model_count, cmp_count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_start_held_through_reset();
        test_reset_mid_scan();
        test_random(256);
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Clocked, parametrised successor to the combinational board-level switch comparator.
- Compares two WIDTH-bit operands in one of three number formats, selected at run time:
  - unsigned
  - two's complement
  - sign-magnitude
- Compares MSB-first, one bit per clock, through a small FSM with early termination.
- Registered outputs drive LEDR (lt/gt/eq), the HEX sign/magnitude displays and a comparison counter. The board top debounces KEY and feeds `start`.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16).
- CNT_W, 8, width of the completed-comparison counter.

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 at board top).
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; only its rising edge (sampled on clk) launches a comparison.
- mode  in  2  number format: 00 unsigned, 01 two's complement, 10 sign-magnitude, 11 reserved.
- a_in  in  WIDTH  operand A (SW upper field).
- b_in  in  WIDTH  operand B (SW lower field).
- busy  out  1  high from the capture edge through the DONE cycle.
- done  out  1  one-cycle pulse when results update.
- eq / gt / lt  out  1 each  one-hot result of A vs B; held until the next completion.
- a_mag / b_mag  out  WIDTH  unsigned magnitude of each operand, for the HEX digits.
- a_neg / b_neg  out  1 each  operand is negative, for the HEX minus sign.
- mode_err  out  1  the last captured mode was 11.
- cmp_count  out  CNT_W  number of completed comparisons.

Behaviour:
- Reset values: every output is 0. FSM goes to IDLE. The start-edge history register resets to 1, so a start held high through reset does not trigger.
- Reset takes priority over all other activity. Reset during LOAD, SCAN or DONE aborts the comparison, with no done pulse and no counter increment.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - On a start rising edge at clock edge N: capture a_in, b_in and mode; set busy=1; go to LOAD.
  - Capture only happens in IDLE. Start edges while busy are ignored and are not queued.
- LOAD (one cycle):
  - Computes sign, magnitude and a (WIDTH+1)-bit biased key for each operand. Key = signed value + 2^(WIDTH-1) for the signed modes, {1'b0, x} for unsigned.
  - Unsigned: neg=0, mag=x.
  - Two's complement: neg=x[MSB], mag=|x|. The most negative value gives mag=2^(WIDTH-1), which is representable in WIDTH bits.
  - Sign-magnitude: mag=x[WIDTH-2:0]; neg=x[MSB] AND mag!=0. Negative zero equals positive zero.
  - Mode 11: treated as unsigned, and mode_err=1.
  - a_mag, b_mag, a_neg, b_neg and mode_err register at the LOAD->SCAN edge.
- SCAN:
  - Each cycle compares one key bit, MSB first, with an index counter running WIDTH..0.
  - At the first differing bit: set gt or lt, go to DONE.
  - If bit 0 is reached with all bits equal: set eq, go to DONE.
  - Scan length k = (index of first difference from MSB) + 1, or WIDTH+1 when the keys are equal.
- Result timing:
  - eq/gt/lt update on the SCAN->DONE edge. That is edge N+1+k when the start edge was sampled at edge N.
  - done=1 for exactly that following cycle, and cmp_count increments on the same edge.
- DONE: one cycle, then IDLE; busy falls on this exit edge. A new start edge is accepted no earlier than the first IDLE cycle.
- Counter wrap: cmp_count wraps from 2^CNT_W-1 to 0.
- Exclusivity: exactly one of eq/gt/lt is high after the first completion; all are 0 before it.

Test Plan (WIDTH=4):
- Unsigned compare: mode=00, a=0111, b=0011, start edge at N → k=3; done after edge N+4; gt=1; a_mag=7, b_mag=3; cmp_count=1.
- Two's-complement extremes: mode=01, a=1000, b=0111 → lt=1; a_neg=1, a_mag=8; b_neg=0, b_mag=7; k=2, so done after edge N+3.
- Negative zero and negative ordering: mode=10, a=1000, b=0000 → eq=1, a_neg=0, k=5, done after edge N+6. Then a=1011, b=1101 → gt=1 (−3 > −5), a_neg=b_neg=1.
- Reserved mode: mode=11, a=0010, b=0010 → eq=1, mode_err=1. A following mode=00 compare clears mode_err.
- Start handling: three start pulses while busy → only one done and cmp_count +1. Start held high across a reset release → no comparison until start falls and rises again.
- Reset mid-comparison: reset asserted during SCAN → next cycle busy=0, done=0, all outputs 0, cmp_count=0. A 256-comparison run wraps cmp_count to 0.
